led_sched: RTL and testbench

Scheduler that shares the single PL LED among N_REQ requesters (heartbeat, fault, user, debug). It runs fixed-priority arbitration with a minimum-hold anti-flicker window, then drives the LED in the granted requester's mode: off, solid, blink or breathe (PWM). It sits between the fabric-clocked status logic and the external LED pin, and replaces the per-function free-running blink/PWM counters.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_pwm.sv | 24 ++
 rtl/led_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_led_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED scheduler: per-requester mode codes, FSM states
// and a counter-width helper that never returns zero.
package led_pkg;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_SOLID   = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// 8-bit free-running PWM: output is high while the counter is below duty,
// so duty 0 is constant low and duty 255 is high 255 of every 256 cycles.
module led_pwm (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] duty,
    output logic       pwm_out
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_cnt == 8'hFF) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign pwm_out = (r_cnt < duty);

endmodule

// File: rtl/led_sched.sv
// Shares one LED among N_REQ requesters: fixed-priority grant with a minimum
// hold window, then off/solid/blink/breathe drive. Breathe needs LED_SCHED_BREATHE_EN.
module led_sched
    import led_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_DIV     = CLK_HZ / 1000,
    parameter int N_REQ        = 4,
    parameter int MIN_HOLD     = 50,
    parameter int BLINK_TICKS  = 500,
    parameter int BREATHE_STEP = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] mode,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic               LED
);

    localparam int TICK_W  = cntWidth(TICK_DIV);
    localparam int HOLD_W  = cntWidth(MIN_HOLD + 1);
    localparam int BLINK_W = cntWidth(BLINK_TICKS);

    logic [TICK_W-1:0]  r_tickCnt;
    logic               w_tick;
    state_t             r_state, w_stateNext;
    logic [N_REQ-1:0]   r_grant, w_grantNext, w_reqFirst;
    logic [HOLD_W-1:0]  r_hold, w_holdNext;
    logic               w_ownerReq, w_higherReq, w_grantChange;
    logic [BLINK_W-1:0] r_blinkCnt;
    logic               r_blinkOn;
    logic               w_breatheLed;
    logic [1:0]         w_ownerMode;
    logic               w_ledNext, r_led;

    assign w_tick = (r_tickCnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + TICK_W'(1);
        end
    end

    always_comb begin
        w_reqFirst = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_reqFirst = N_REQ'(1) << i;
            end
        end
    end

    // Bits below the owner's one-hot position are exactly the higher-priority requesters.
    assign w_ownerReq  = |(req & r_grant);
    assign w_higherReq = |(req & (r_grant - N_REQ'(1)));

    always_comb begin
        w_stateNext = r_state;
        w_grantNext = r_grant;
        w_holdNext  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_grantNext = w_reqFirst;
                    w_holdNext  = HOLD_W'(MIN_HOLD);
                    w_stateNext = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!w_ownerReq) begin
                    w_grantNext = '0;
                    w_holdNext  = '0;
                    w_stateNext = ST_IDLE;
                end else if (r_hold == '0) begin
                    w_stateNext = ST_OWN;
                end else if (w_tick) begin
                    w_holdNext = r_hold - HOLD_W'(1);
                    if (r_hold == HOLD_W'(1)) begin
                        w_stateNext = ST_OWN;
                    end
                end
            end
            ST_OWN: begin
                if (!w_ownerReq) begin
                    w_grantNext = '0;
                    w_stateNext = ST_IDLE;
                end else if (w_higherReq) begin
                    w_grantNext = w_reqFirst;
                    w_holdNext  = HOLD_W'(MIN_HOLD);
                    w_stateNext = ST_HOLD;
                end
            end
            default: begin
                w_grantNext = '0;
                w_holdNext  = '0;
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_grant <= w_grantNext;
            r_hold  <= w_holdNext;
        end
    end

    assign w_grantChange = (w_grantNext != r_grant);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blinkCnt <= '0;
            r_blinkOn  <= 1'b1;
        end else if (w_grantChange) begin
            r_blinkCnt <= '0;
            r_blinkOn  <= 1'b1;
        end else if (w_tick) begin
            if (r_blinkCnt == BLINK_W'(BLINK_TICKS - 1)) begin
                r_blinkCnt <= '0;
                r_blinkOn  <= ~r_blinkOn;
            end else begin
                r_blinkCnt <= r_blinkCnt + BLINK_W'(1);
            end
        end
    end

`ifdef LED_SCHED_BREATHE_EN
    localparam int STEP_W = cntWidth(BREATHE_STEP);

    logic [STEP_W-1:0] r_stepCnt;
    logic [7:0]        r_duty;
    logic              r_dirUp;
    logic              w_pwm;

    // Triangle ramp: turns at 255 and 0 on the step itself, so neither end is held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stepCnt <= '0;
            r_duty    <= '0;
            r_dirUp   <= 1'b1;
        end else if (w_grantChange) begin
            r_stepCnt <= '0;
            r_duty    <= '0;
            r_dirUp   <= 1'b1;
        end else if (w_tick) begin
            if (r_stepCnt == STEP_W'(BREATHE_STEP - 1)) begin
                r_stepCnt <= '0;
                if (r_dirUp) begin
                    if (r_duty == 8'hFF) begin
                        r_dirUp <= 1'b0;
                        r_duty  <= 8'hFE;
                    end else begin
                        r_duty <= r_duty + 8'd1;
                    end
                end else begin
                    if (r_duty == 8'h00) begin
                        r_dirUp <= 1'b1;
                        r_duty  <= 8'h01;
                    end else begin
                        r_duty <= r_duty - 8'd1;
                    end
                end
            end else begin
                r_stepCnt <= r_stepCnt + STEP_W'(1);
            end
        end
    end

    led_pwm u_pwm (
        .clk     (clk),
        .reset_n (reset_n),
        .duty    (r_duty),
        .pwm_out (w_pwm)
    );

    assign w_breatheLed = w_pwm;
`else
    assign w_breatheLed = 1'b1;
`endif

    always_comb begin
        w_ownerMode = MODE_OFF;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_ownerMode = mode[2*i +: 2];
            end
        end
    end

    // Gating on the owner's live request blanks the LED in the same cycle the grant drops.
    always_comb begin
        w_ledNext = 1'b0;
        if (w_ownerReq) begin
            case (w_ownerMode)
                MODE_SOLID:   w_ledNext = 1'b1;
                MODE_BLINK:   w_ledNext = r_blinkOn;
                MODE_BREATHE: w_ledNext = w_breatheLed;
                default:      w_ledNext = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= w_ledNext;
        end
    end

    assign grant = r_grant;
    assign busy  = |r_grant;
    assign LED   = r_led;

endmodule

// File: tb/tb_led_sched.sv
// Scoreboard bench for led_sched: a tick-counting reference model predicts
// grant/busy/LED per edge; a monitor compares. Honours LED_SCHED_BREATHE_EN.
module tb_led_sched;

    localparam int TD = 4;
    localparam int NR = 4;
    localparam int MH = 3;
    localparam int BT = 2;
    localparam int BS = 1;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [NR-1:0] req     = '0;
    logic [2*NR-1:0] mode  = '0;
    logic [NR-1:0] grant;
    logic          busy;
    logic          LED;

    typedef struct packed {
        logic [NR-1:0] grant;
        logic          busy;
        logic          led;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    int   mOwner = -1;
    int   mTicks = 0;
    int   mEdge  = 0;

    led_sched #(
        .CLK_HZ       (4000),
        .TICK_DIV     (TD),
        .N_REQ        (NR),
        .MIN_HOLD     (MH),
        .BLINK_TICKS  (BT),
        .BREATHE_STEP (BS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .mode    (mode),
        .grant   (grant),
        .busy    (busy),
        .LED     (LED)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endfunction

    function automatic int lowestReq(input logic [NR-1:0] r);
        for (int i = 0; i < NR; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    // Duty after a number of breathe steps: triangle 0..255..0 with period 510.
    function automatic int triDuty(input int steps);
        int p;
        p = steps % 510;
        return (p <= 255) ? p : 510 - p;
    endfunction

    function automatic logic patternLed(input int m, input int k, input int e);
        case (m)
            0: return 1'b0;
            1: return 1'b1;
            2: return ((k / BT) % 2) == 0;
            default: begin
`ifdef LED_SCHED_BREATHE_EN
                return ((e - 1) % 256) < triDuty(k / BS);
`else
                return (e > 0);
`endif
            end
        endcase
    endfunction

    // Advance the reference by one clock edge using the inputs just driven.
    function automatic void modelEdge();
        exp_t x;
        int   lo;
        int   m;
        logic tick;
        mEdge++;
        tick = ((mEdge % TD) == 0);
        x.led = 1'b0;
        if (mOwner >= 0 && req[mOwner]) begin
            m = int'((mode >> (2 * mOwner)) & 8'd3);
            x.led = patternLed(m, mTicks, mEdge);
        end
        lo = lowestReq(req);
        if (mOwner < 0) begin
            if (lo >= 0) begin
                mOwner = lo;
                mTicks = 0;
            end
        end else if (!req[mOwner]) begin
            mOwner = -1;
        end else if (mTicks >= MH && lo < mOwner) begin
            mOwner = lo;
            mTicks = 0;
        end else if (tick) begin
            mTicks++;
        end
        x.grant = (mOwner >= 0) ? NR'(1) << mOwner : '0;
        x.busy  = (mOwner >= 0);
        sbQ.push_back(x);
    endfunction

    task automatic driveNow(input logic [NR-1:0] r, input logic [2*NR-1:0] m);
        req  = r;
        mode = m;
        modelEdge();
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r, input logic [2*NR-1:0] m);
        @(negedge clk);
        driveNow(r, m);
    endtask

    // Asserts reset between edges so the zero checks prove it is asynchronous.
    task automatic doReset(input int cycles, input logic [NR-1:0] relReq, input logic [2*NR-1:0] relMode);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        req     = 4'b1111;
        #1;
        checkOutput("async_rst_grant", int'(grant), 0);
        checkOutput("async_rst_busy", int'(busy), 0);
        checkOutput("async_rst_led", int'(LED), 0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput("rst_grant", int'(grant), 0);
            checkOutput("rst_led", int'(LED), 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        mEdge   = 0;
        mOwner  = -1;
        mTicks  = 0;
        driveNow(relReq, relMode);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sbQ.size() > 0) begin
                x = sbQ.pop_front();
                checkOutput("grant", int'(grant), int'(x.grant));
                checkOutput("busy", int'(busy), int'(x.busy));
                checkOutput("led", int'(LED), int'(x.led));
            end
        end
    end

    initial begin : stimulus
        logic [NR-1:0]   curReq;
        logic [2*NR-1:0] curMode;

        doReset(3, 4'b1111, 8'b0000_0001);
        repeat (6)    applyStimulus(4'b1111, 8'b0000_0001);
        repeat (2)    applyStimulus(4'b0000, 8'h00);
        repeat (40)   applyStimulus(4'b0100, 8'b0010_0000);
        repeat (2)    applyStimulus(4'b0000, 8'h00);
        repeat (3)    applyStimulus(4'b1000, 8'b1010_1010);
        repeat (30)   applyStimulus(4'b1010, 8'b1010_1010);
        repeat (2)    applyStimulus(4'b0000, 8'h00);
        repeat (20)   applyStimulus(4'b0101, 8'b0001_0001);
        repeat (10)   applyStimulus(4'b0100, 8'b0001_0001);
        repeat (2)    applyStimulus(4'b0000, 8'h00);
        repeat (2300) applyStimulus(4'b0010, 8'b0000_1100);
        repeat (2)    applyStimulus(4'b0000, 8'h00);
        repeat (4)    applyStimulus(4'b0100, 8'b0010_0000);
        doReset(2, 4'b0000, 8'h00);

        curReq  = '0;
        curMode = 8'($urandom_range(0, 255));
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 29) == 0) curReq = NR'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) curMode = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1999) == 0) begin
                doReset(1, curReq, curMode);
            end else begin
                applyStimulus(curReq, curMode);
            end
        end

        @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", sbQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
